// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone single-master interconnect: default
// address map, error data, FSM encoding and a width helper.
package wb_pkg;

   localparam int DEF_NUM_SLAVES = 4;

   // Slave i occupies bits [i*16 +: 16]; slave 0 is the rightmost entry.
   localparam logic [63:0] DEF_SLAVE_BASE = {16'h8200, 16'h8100, 16'h8000, 16'h0000};
   localparam logic [63:0] DEF_SLAVE_MASK = {16'hFE00, 16'hFF00, 16'hFF00, 16'h8000};

   localparam logic [7:0] DEF_ERR_DATA = 8'hEE;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_ERROR  = 2'd2
   } wb_state_e;

   // Bits needed to hold values 0..value-1, never less than one.
   function automatic int wb_clog2(input int value);
      int w;
      w = 1;
      while ((1 << w) < value) w++;
      return w;
   endfunction

endpackage

// File: rtl/wb_addr_match.sv
// Address comparators for every slave window plus a lowest-index priority
// encoder, so overlapping windows resolve deterministically.
module wb_addr_match
   import wb_pkg::*;
#(
   parameter int                            NUM_SLAVES = DEF_NUM_SLAVES,
   parameter int                            ADR_W      = 16,
   parameter int                            SEL_W      = wb_clog2(NUM_SLAVES),
   parameter logic [NUM_SLAVES*ADR_W-1:0]   SLAVE_BASE = DEF_SLAVE_BASE,
   parameter logic [NUM_SLAVES*ADR_W-1:0]   SLAVE_MASK = DEF_SLAVE_MASK
) (
   input  logic [ADR_W-1:0] adr_i,
   output logic             hit_o,
   output logic [SEL_W-1:0] sel_o
);

   logic [ADR_W-1:0] base_w;
   logic [ADR_W-1:0] mask_w;

   // Walk from the top down so the lowest matching index is the last writer.
   always_comb begin
      hit_o  = 1'b0;
      sel_o  = '0;
      base_w = '0;
      mask_w = '0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         base_w = SLAVE_BASE[i*ADR_W +: ADR_W];
         mask_w = SLAVE_MASK[i*ADR_W +: ADR_W];
         if ((adr_i & mask_w) == (base_w & mask_w)) begin
            hit_o = 1'b1;
            sel_o = SEL_W'(i);
         end
      end
   end

endmodule

// File: rtl/wb_interconnect_n.sv
// Wishbone classic single master to N slaves: registered slave select,
// bus error on unmapped addresses, watchdog for slaves that never ack.
module wb_interconnect_n
   import wb_pkg::*;
#(
   parameter int                            NUM_SLAVES = DEF_NUM_SLAVES,
   parameter int                            ADR_W      = 16,
   parameter int                            DAT_W      = 8,
   parameter int                            SLV_ADR_W  = 15,
   parameter logic [NUM_SLAVES*ADR_W-1:0]   SLAVE_BASE = DEF_SLAVE_BASE,
   parameter logic [NUM_SLAVES*ADR_W-1:0]   SLAVE_MASK = DEF_SLAVE_MASK,
   parameter int                            TIMEOUT    = 255,
   parameter logic [DAT_W-1:0]              ERR_DATA   = DEF_ERR_DATA
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [ADR_W-1:0]            wb_adr_i,
   input  logic [DAT_W-1:0]            wb_dat_i,
   output logic [DAT_W-1:0]            wb_dat_o,
   input  logic                        wb_cyc_i,
   input  logic                        wb_stb_i,
   input  logic                        wb_we_i,
   output logic                        wb_ack_o,
   output logic                        wb_err_o,
   output logic [SLV_ADR_W-1:0]        s_adr_o,
   output logic [DAT_W-1:0]            s_dat_o,
   output logic                        s_we_o,
   input  logic [NUM_SLAVES*DAT_W-1:0] s_dat_i,
   output logic [NUM_SLAVES-1:0]       s_cyc_o,
   output logic [NUM_SLAVES-1:0]       s_stb_o,
   input  logic [NUM_SLAVES-1:0]       s_ack_i,
   output logic                        err_flag_o,
   output logic [ADR_W-1:0]            err_addr_o,
   input  logic                        err_clr_i
);

   localparam int SEL_W = wb_clog2(NUM_SLAVES);
   localparam int CNT_W = wb_clog2(TIMEOUT + 1);

   wb_state_e        state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_flag_q, err_flag_d;
   logic [ADR_W-1:0] err_addr_q, err_addr_d;

   logic             hit;
   logic [SEL_W-1:0] hit_sel;
   logic             timeout_hit;
   logic             slave_live;
   logic             ack_sel;
   logic [DAT_W-1:0] dat_sel;
   logic             enter_err;

   wb_addr_match #(
      .NUM_SLAVES (NUM_SLAVES),
      .ADR_W      (ADR_W),
      .SEL_W      (SEL_W),
      .SLAVE_BASE (SLAVE_BASE),
      .SLAVE_MASK (SLAVE_MASK)
   ) u_match (
      .adr_i (wb_adr_i),
      .hit_o (hit),
      .sel_o (hit_sel)
   );

   assign s_adr_o = wb_adr_i[SLV_ADR_W-1:0];
   assign s_dat_o = wb_dat_i;
   assign s_we_o  = wb_we_i;

   // On the watchdog cycle the slave is already released, so a late ack is dropped.
   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));
   assign slave_live  = (state_q == ST_ACTIVE) && !timeout_hit;

   always_comb begin
      ack_sel = 1'b0;
      dat_sel = '0;
      s_cyc_o = '0;
      s_stb_o = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (sel_q == SEL_W'(i)) begin
            ack_sel    = s_ack_i[i];
            dat_sel    = s_dat_i[i*DAT_W +: DAT_W];
            s_cyc_o[i] = slave_live & wb_cyc_i;
            s_stb_o[i] = slave_live & wb_cyc_i & wb_stb_i;
         end
      end
   end

   assign wb_ack_o = slave_live & wb_cyc_i & ack_sel;
   assign wb_err_o = (state_q == ST_ERROR);

   always_comb begin
      case (state_q)
         ST_ACTIVE: wb_dat_o = dat_sel;
         ST_ERROR:  wb_dat_o = ERR_DATA;
         default:   wb_dat_o = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = '0;
      case (state_q)
         ST_IDLE: begin
            if (wb_cyc_i && wb_stb_i) begin
               if (hit) begin
                  sel_d   = hit_sel;
                  state_d = ST_ACTIVE;
               end else begin
                  state_d = ST_ERROR;
               end
            end
         end
         ST_ACTIVE: begin
            if (!wb_cyc_i) begin
               state_d = ST_IDLE;
            end else if (timeout_hit) begin
               state_d = ST_ERROR;
            end else if (ack_sel) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A clear arriving with a new error still logs that new error.
   assign enter_err = (state_d == ST_ERROR) && (state_q != ST_ERROR);

   always_comb begin
      err_flag_d = err_flag_q;
      err_addr_d = err_addr_q;
      if (enter_err && (!err_flag_q || err_clr_i)) begin
         err_flag_d = 1'b1;
         err_addr_d = wb_adr_i;
      end else if (err_clr_i) begin
         err_flag_d = 1'b0;
         err_addr_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         sel_q      <= '0;
         cnt_q      <= '0;
         err_flag_q <= 1'b0;
         err_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         cnt_q      <= cnt_d;
         err_flag_q <= err_flag_d;
         err_addr_q <= err_addr_d;
      end
   end

   assign err_flag_o = err_flag_q;
   assign err_addr_o = err_addr_q;

endmodule
